enemy_missile_spawner: RTL and testbench
========================================

// Module: enemy_missile_spawner
// PURPOSE
// - Consumes the pseudo-random bit stream of the enemy missile shift register and decides, once per game tick, whether to launch an enemy missile.
// - Picks a free missile slot, a start X and a target city, and hands each launch to the missile engine over a valid/ready handshake.
// - Counts down a per-wave missile budget and flags wave completion.
// PARAMETERS
// - NUM_SLOTS      4    concurrent enemy missile slots in the missile engine (1..8)
// - WAVE_MISSILES  10   launches per wave (1..255)
// - COOLDOWN       8    ticks to wait after a launch before the next decision (0..255)
// - X_OFFSET       64   added to the random X field; the launch_x range is 64..575
// PORTS
// - clk            in   1           system clock
// - reset          in   1           synchronous, active-high reset
// - rand_bit       in   1           serial random bit from the enemy missile shift register, one new bit per clk
// - tick           in   1           game-tick strobe, 1 clk wide
// - wave_start     in   1           1-clk pulse: arm a new wave
// - slot_free      in   NUM_SLOTS   bit i = 1 when engine slot i is idle
// - launch_valid   out  1           launch request pending
// - launch_ready   in   1           engine accepts the request
// - launch_slot    out  3           slot index for this launch
// - launch_x       out  10          start X pixel
// - launch_target  out  3           target city, 0..5
// - missiles_left  out  8           launches remaining in the current wave
// - wave_done      out  1           high in DONE
// BEHAVIOUR
// - One clock (clk). Reset is synchronous and active-high (reset).
// - Reset values: state=IDLE; launch_valid=0; launch_slot/x/target=0; missiles_left=0; wave_done=0; cooldown count=0; accumulator=0.
// - Accumulator: acc <= {acc[14:0], rand_bit} on every clk, in every state except during reset.
// - State IDLE: on wave_start, load missiles_left=WAVE_MISSILES and cool=0, then go to ARMED.
// - State ARMED: evaluate only on a clk where tick=1:
//   - If cool!=0: cool decrements by 1 and the state does not change.
//   - Else if acc[0]==1 and |slot_free: latch the outputs below, then go to LAUNCH.
//       - launch_slot = lowest set index of slot_free.
//       - launch_x = acc[9:1] + X_OFFSET.
//       - launch_target = acc[12:10], with 6→2 and 7→3.
//   - Else: no action; the next tick is evaluated again.
// - State LAUNCH: launch_valid=1.
//   - slot/x/target are held stable until launch_ready; ticks are ignored.
//   - On valid&ready (same edge): missiles_left decrements and cool=COOLDOWN. If the new missiles_left==0, go to DONE; otherwise go to ARMED. launch_valid is 0 in the next cycle.
// - State DONE: wave_done=1. On wave_start, reload the budget exactly as in IDLE and go to ARMED.
// - wave_start in ARMED or LAUNCH is ignored; a wave cannot be restarted mid-flight.
// - slot_free changing while in LAUNCH does not alter the latched slot. The engine owns any conflict and must deassert launch_ready.
// - Latency: decision edge → launch_valid is 1 clk. With launch_ready tied high, a launch completes 2 clks after its tick.
// - Reset asserted mid-LAUNCH: launch_valid drops at that edge and no decrement occurs.
// CONFIGURATION
// - Macro ENEMY_SPAWN_STATS_EN defined: adds output launch_total[15:0].
//   - It increments on each valid&ready handshake and saturates at 16'hFFFF.
//   - It is cleared only by reset, not by wave_start.
// - Macro not defined: the port and counter are absent; all other behaviour is identical.
// STRUCTURE
// - Package enemy_spawn_pkg holds:
//   - typedef enum spawn_state_t {IDLE, ARMED, LAUNCH, DONE}
//   - constants NUM_CITIES=6, X_W=10, TARGET_W=3, SLOT_W=3, ACC_W=16
// - Sub-module spawn_slot_picker: a parameterised lowest-set-bit priority encoder. Inputs: slot_free. Outputs: idx[SLOT_W-1:0] and any.
// - The top level holds the accumulator, FSM, cooldown counter, budget counter and output registers.
// TESTING
// - Reset then idle: 20 clks with tick pulses and no wave_start → launch_valid=0, wave_done=0, missiles_left=0.
// - Forced stream: wave_start, slot_free=4'b0110, launch_ready=1, rand_bit driven so that acc=16'h0C03 at a tick.
//   - Required: launch_slot=1, launch_x=1+64=65, launch_target=3, missiles_left=9.
// - Backpressure: launch_ready=0 for 5 clks while in LAUNCH → launch_valid held high and slot/x/target unchanged; ready=1 → one decrement only.
// - Cooldown: after a launch with COOLDOWN=8 and acc[0]=1 on every tick → next launch_valid only after the 9th tick.
// - No free slot: slot_free=0 and acc[0]=1 for 10 ticks → no launch; set slot_free=4'b1000 → launch_slot=3 at the next tick.
// - Wave end and reset: WAVE_MISSILES=2 → wave_done after 2 handshakes, and wave_start in DONE re-arms.
//   - Reset asserted during LAUNCH → launch_valid=0 at the next clk and state=IDLE.
//   - With ENEMY_SPAWN_STATS_EN: launch_total counts 2 and survives wave_start.

Source files
------------

// File: rtl/enemy_spawn_pkg.sv
// Shared types and constants for the enemy missile spawner.
package enemy_spawn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LAUNCH = 2'd2,
    DONE   = 2'd3
  } spawn_state_t;

  localparam int NUM_CITIES = 6;
  localparam int X_W        = 10;
  localparam int TARGET_W   = 3;
  localparam int SLOT_W     = 3;
  localparam int ACC_W      = 16;

  // Raw 3-bit target codes 6 and 7 fold back onto cities 2 and 3.
  function automatic logic [TARGET_W-1:0] fold_target(input logic [TARGET_W-1:0] raw);
    fold_target = (raw >= TARGET_W'(NUM_CITIES)) ? (raw - 3'd4) : raw;
  endfunction

endpackage

// File: rtl/spawn_slot_picker.sv
// Lowest-set-bit priority encoder selecting the free missile slot.
module spawn_slot_picker
  import enemy_spawn_pkg::*;
#(
  parameter int NUM_SLOTS = 4
) (
  input  logic [NUM_SLOTS-1:0] slot_free,
  output logic [SLOT_W-1:0]    idx,
  output logic                 any
);

  // Scan from the top so the lowest free index wins.
  always_comb begin
    idx = '0;
    any = |slot_free;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      idx = slot_free[i] ? SLOT_W'(i) : idx;
    end
  end

endmodule

// File: rtl/enemy_missile_spawner.sv
// Enemy missile launch scheduler: random decision per tick, slot pick, valid/ready hand-off.
// Optional ENEMY_SPAWN_STATS_EN adds a saturating launch_total counter.
module enemy_missile_spawner
  import enemy_spawn_pkg::*;
#(
  parameter int NUM_SLOTS     = 4,
  parameter int WAVE_MISSILES = 10,
  parameter int COOLDOWN      = 8,
  parameter int X_OFFSET      = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rand_bit,
  input  logic                 tick,
  input  logic                 wave_start,
  input  logic [NUM_SLOTS-1:0] slot_free,
  output logic                 launch_valid,
  input  logic                 launch_ready,
  output logic [SLOT_W-1:0]    launch_slot,
  output logic [X_W-1:0]       launch_x,
  output logic [TARGET_W-1:0]  launch_target,
  output logic [7:0]           missiles_left,
`ifdef ENEMY_SPAWN_STATS_EN
  output logic [15:0]          launch_total,
`endif
  output logic                 wave_done
);

  spawn_state_t          state_q, state_d;
  logic [ACC_W-1:0]      acc_q;
  logic [7:0]            cool_q, cool_d;
  logic [7:0]            left_q, left_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [X_W-1:0]        x_q, x_d;
  logic [TARGET_W-1:0]   target_q, target_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic                  handshake_s;
  logic [SLOT_W-1:0]     pick_idx_s;
  logic                  pick_any_s;
  logic                  unused_acc_s;

  assign unused_acc_s = ^acc_q[ACC_W-1:13];

  spawn_slot_picker #(
    .NUM_SLOTS(NUM_SLOTS)
  ) u_picker (
    .slot_free(slot_free),
    .idx      (pick_idx_s),
    .any      (pick_any_s)
  );

  // Next-state, counters and launch payload.
  always_comb begin
    state_d     = state_q;
    cool_d      = cool_q;
    left_d      = left_q;
    slot_d      = slot_q;
    x_d         = x_q;
    target_d    = target_q;
    handshake_s = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (wave_start) begin
          left_d  = 8'(WAVE_MISSILES);
          cool_d  = 8'd0;
          state_d = ARMED;
        end else begin
          state_d = state_q;
        end
      end
      ARMED: begin
        if (!tick) begin
          state_d = ARMED;
        end else if (cool_q != 8'd0) begin
          cool_d = cool_q - 8'd1;
        end else if (acc_q[0] && pick_any_s) begin
          slot_d   = pick_idx_s;
          x_d      = X_W'(acc_q[9:1]) + X_W'(X_OFFSET);
          target_d = fold_target(acc_q[12:10]);
          state_d  = LAUNCH;
        end else begin
          state_d = ARMED;
        end
      end
      LAUNCH: begin
        if (launch_ready) begin
          handshake_s = 1'b1;
          left_d      = left_q - 8'd1;
          cool_d      = 8'(COOLDOWN);
          state_d     = (left_q == 8'd1) ? DONE : ARMED;
        end else begin
          state_d = LAUNCH;
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == LAUNCH);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cool_q   <= 8'd0;
      left_q   <= 8'd0;
      slot_q   <= '0;
      x_q      <= '0;
      target_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= {acc_q[ACC_W-2:0], rand_bit};
      cool_q   <= cool_d;
      left_q   <= left_d;
      slot_q   <= slot_d;
      x_q      <= x_d;
      target_q <= target_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

`ifdef ENEMY_SPAWN_STATS_EN
  logic [15:0] total_q;

  // Lifetime handshake count; survives wave restarts.
  always_ff @(posedge clk) begin
    if (reset) begin
      total_q <= 16'd0;
    end else if (handshake_s && (total_q != 16'hFFFF)) begin
      total_q <= total_q + 16'd1;
    end else begin
      total_q <= total_q;
    end
  end

  assign launch_total = total_q;
`else
  logic unused_handshake_s;
  assign unused_handshake_s = handshake_s;
`endif

  assign launch_valid  = valid_q;
  assign launch_slot   = slot_q;
  assign launch_x      = x_q;
  assign launch_target = target_q;
  assign missiles_left = left_q;
  assign wave_done     = done_q;

endmodule

// File: tb/tb_enemy_missile_spawner.sv
// Randomised and directed bench for enemy_missile_spawner against a behavioural launch model.
module tb_enemy_missile_spawner;

  localparam int NS   = 4;
  localparam int WAVE = 10;
  localparam int COOL = 8;
  localparam int XOFF = 64;

  logic          clk = 1'b0;
  logic          reset, rand_bit, tick, wave_start, launch_ready;
  logic [NS-1:0] slot_free;
  logic          launch_valid, wave_done;
  logic [2:0]    launch_slot, launch_target;
  logic [9:0]    launch_x;
  logic [7:0]    missiles_left;
`ifdef ENEMY_SPAWN_STATS_EN
  logic [15:0]   launch_total;
`endif

  always #5 clk = ~clk;

  enemy_missile_spawner #(
    .NUM_SLOTS(NS), .WAVE_MISSILES(WAVE), .COOLDOWN(COOL), .X_OFFSET(XOFF)
  ) dut (
    .clk(clk), .reset(reset), .rand_bit(rand_bit), .tick(tick),
    .wave_start(wave_start), .slot_free(slot_free),
    .launch_valid(launch_valid), .launch_ready(launch_ready),
    .launch_slot(launch_slot), .launch_x(launch_x), .launch_target(launch_target),
    .missiles_left(missiles_left),
`ifdef ENEMY_SPAWN_STATS_EN
    .launch_total(launch_total),
`endif
    .wave_done(wave_done)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model: wave activity flags, pending launch record, history-word accumulator.
  int m_acc, m_left, m_cool, m_slot, m_x, m_tgt, m_total;
  bit m_active, m_pending, m_done;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_edge(input bit r, input bit rb, input bit tk, input bit ws,
                            input int sf, input bit rdy);
    int s;
    if (r) begin
      m_acc = 0; m_left = 0; m_cool = 0; m_slot = 0; m_x = 0; m_tgt = 0; m_total = 0;
      m_active = 0; m_pending = 0; m_done = 0;
    end else begin
      if (m_pending) begin
        if (rdy) begin
          m_pending = 0;
          m_left    = m_left - 1;
          m_cool    = COOL;
          if (m_total < 65535) m_total++;
          if (m_left == 0) begin
            m_active = 0;
            m_done   = 1;
          end
        end
      end else if (m_active) begin
        if (tk) begin
          if (m_cool > 0) m_cool--;
          else if ((m_acc % 2) == 1 && sf != 0) begin
            s = 0;
            while (((sf >> s) & 1) == 0) s++;
            m_slot = s;
            m_x    = (m_acc / 2) % 512 + XOFF;
            m_tgt  = (m_acc / 1024) % 8;
            if (m_tgt > 5) m_tgt = m_tgt - 4;
            m_pending = 1;
          end
        end
      end else if (ws) begin
        m_left = WAVE; m_cool = 0; m_active = 1; m_done = 0;
      end
      m_acc = (m_acc * 2 + int'(rb)) % 65536;
    end
  endtask

  task automatic compare_all();
    check_val("launch_valid", int'(launch_valid), int'(m_pending));
    check_val("wave_done", int'(wave_done), int'(m_done));
    check_val("missiles_left", int'(missiles_left), m_left);
    check_val("launch_slot", int'(launch_slot), m_slot);
    check_val("launch_x", int'(launch_x), m_x);
    check_val("launch_target", int'(launch_target), m_tgt);
`ifdef ENEMY_SPAWN_STATS_EN
    check_val("launch_total", int'(launch_total), m_total);
`endif
  endtask

  task automatic step(input bit r, input bit rb, input bit tk, input bit ws,
                      input int sf, input bit rdy);
    reset = r; rand_bit = rb; tick = tk; wave_start = ws;
    slot_free = sf[NS-1:0]; launch_ready = rdy;
    @(posedge clk);
    model_edge(r, rb, tk, ws, sf, rdy);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [15:0] pat;
    int ticks, seen, sf;
    bit got;

    reset = 1'b1; rand_bit = 1'b0; tick = 1'b0; wave_start = 1'b0;
    slot_free = '0; launch_ready = 1'b0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 15, 1);

    // Idle: ticks without wave_start never launch.
    for (int i = 0; i < 20; i++) step(0, $urandom_range(0, 1), (i % 2) == 0, 0, 15, 1);
    check_val("idle_valid", int'(launch_valid), 0);
    check_val("idle_left", int'(missiles_left), 0);

    // Forced stream to acc = 16'h0C03, then decide on a tick.
    step(0, 0, 0, 1, 6, 0);
    pat = 16'h0C03;
    for (int b = 15; b >= 0; b--) step(0, pat[b], 0, 0, 6, 0);
    step(0, 0, 1, 0, 6, 0);
    check_val("forced_valid", int'(launch_valid), 1);
    check_val("forced_slot", int'(launch_slot), 1);
    check_val("forced_x", int'(launch_x), 65);
    check_val("forced_target", int'(launch_target), 3);

    // Backpressure: payload held while not ready, slot_free and ticks ignored.
    for (int i = 0; i < 5; i++) step(0, $urandom_range(0, 1), i % 2, 1, $urandom_range(0, 15), 0);
    check_val("bp_valid", int'(launch_valid), 1);
    check_val("bp_slot", int'(launch_slot), 1);
    check_val("bp_x", int'(launch_x), 65);
    step(0, 1, 0, 0, 6, 1);
    check_val("bp_left", int'(missiles_left), 9);
    check_val("bp_valid_drop", int'(launch_valid), 0);

    // Cooldown: next launch appears right after the 9th tick.
    ticks = 0;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      step(0, 1, (i % 3) == 0, 0, 15, 1);
      if ((i % 3) == 0) ticks++;
      if (launch_valid) got = 1;
    end
    check_val("cool_ticks", ticks, 9);
    step(0, 1, 0, 0, 15, 1);

    // No free slot: cooldown then 10 more ticks with no launch.
    seen = 0;
    for (int i = 0; i < 36; i++) begin
      step(0, 1, (i % 2) == 0, 0, 0, 1);
      if (launch_valid) seen++;
    end
    check_val("noslot_launches", seen, 0);
    step(0, 1, 1, 0, 8, 0);
    check_val("noslot_valid", int'(launch_valid), 1);
    check_val("noslot_slot", int'(launch_slot), 3);
    step(0, 1, 0, 0, 8, 1);

    // Finish the wave, then re-arm from DONE.
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      step(0, 1, (i % 2) == 0, 0, 15, 1);
      if (wave_done) got = 1;
    end
    check_val("wave_done", int'(wave_done), 1);
    check_val("wave_left", int'(missiles_left), 0);
`ifdef ENEMY_SPAWN_STATS_EN
    check_val("total_wave", int'(launch_total), WAVE);
`endif
    step(0, 1, 0, 1, 15, 1);
    check_val("rearm_done", int'(wave_done), 0);
    check_val("rearm_left", int'(missiles_left), WAVE);
`ifdef ENEMY_SPAWN_STATS_EN
    check_val("total_kept", int'(launch_total), WAVE);
`endif

    // Reset while a launch is pending.
    step(0, 1, 1, 0, 15, 0);
    step(0, 1, 0, 0, 15, 0);
    check_val("pre_rst_valid", int'(launch_valid), 1);
    step(1, 1, 0, 0, 15, 1);
    check_val("rst_valid", int'(launch_valid), 0);
    check_val("rst_left", int'(missiles_left), 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1, 0, 15, 1);
      if (launch_valid) seen++;
    end
    check_val("rst_idle", seen, 0);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      sf = $urandom_range(0, 15);
      step($urandom_range(0, 299) == 0, $urandom_range(0, 1), $urandom_range(0, 3) == 0,
           $urandom_range(0, 15) == 0, sf, $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
